// File: rtl/spi_cmd_decoder.sv
// Command decoder behind an SPI slave byte receiver: it decodes a command byte, runs
// burst writes and reads on a local 8-bit register bank, and supplies the next MISO byte.
module spi_cmd_decoder #(
  parameter int NUM_REGS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter logic [7:0] ERR_BYTE = 8'hEE
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        frame_end,
  input  logic                        rx_valid,
  input  logic [7:0]                  rx_byte,
  output logic [7:0]                  tx_byte,
  output logic                        tx_load,
  output logic [8*NUM_REGS-1:0]       regs_flat,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  err_cnt,
  output logic                        busy
);

  localparam int AW = $clog2(NUM_REGS);
  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  typedef enum logic [2:0] {IDLE, CMD, WRITE, READ, DISCARD} state_t;

  state_t          state_reg, state_next;
  logic [AW-1:0]   addr_reg, addr_next, addr_inc;
  logic [7:0]      tx_byte_reg, tx_byte_next;
  logic            tx_load_reg, tx_load_next;
  logic [7:0]      err_cnt_reg, err_cnt_next;
  logic            wr_strobe_reg;
  logic [AW-1:0]   wr_addr_reg;
  logic            busy_reg;
  logic            wr_en;
  logic [7:0]      regs_reg [NUM_REGS];

  // The AW-bit sum wraps, so bursts roll over from NUM_REGS-1 to 0.
  assign addr_inc = addr_reg + AW'(1);

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    tx_byte_next = tx_byte_reg;
    tx_load_next = 1'b0;
    err_cnt_next = err_cnt_reg;
    wr_en        = 1'b0;

    if (frame_start) begin
      state_next   = CMD;
      tx_byte_next = SYNC_BYTE;
      tx_load_next = 1'b1;
    end else begin
      if (rx_valid) begin
        case (state_reg)
          CMD: begin
            if ({1'b0, rx_byte[6:0]} >= NUM_REGS_B) begin
              state_next   = DISCARD;
              tx_byte_next = ERR_BYTE;
              tx_load_next = 1'b1;
              if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
            end else if (rx_byte[7]) begin
              state_next   = WRITE;
              addr_next    = rx_byte[AW-1:0];
              tx_byte_next = rx_byte;
              tx_load_next = 1'b1;
            end else begin
              state_next   = READ;
              addr_next    = rx_byte[AW-1:0];
              tx_byte_next = regs_reg[rx_byte[AW-1:0]];
              tx_load_next = 1'b1;
            end
          end
          WRITE: begin
            wr_en        = 1'b1;
            addr_next    = addr_inc;
            tx_byte_next = rx_byte;
            tx_load_next = 1'b1;
          end
          READ: begin
            addr_next    = addr_inc;
            tx_byte_next = regs_reg[addr_inc];
            tx_load_next = 1'b1;
          end
          default: ;
        endcase
      end
      // Evaluated after the byte so a same-cycle rx_valid still takes effect first.
      if (frame_end && state_reg != IDLE) begin
        state_next   = IDLE;
        tx_byte_next = 8'h00;
        tx_load_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      tx_byte_reg   <= 8'h00;
      tx_load_reg   <= 1'b0;
      err_cnt_reg   <= 8'h00;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      tx_byte_reg   <= tx_byte_next;
      tx_load_reg   <= tx_load_next;
      err_cnt_reg   <= err_cnt_next;
      wr_strobe_reg <= wr_en;
      if (wr_en) wr_addr_reg <= addr_reg;
      busy_reg      <= (state_next != IDLE);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_regs
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= 8'h00;
        end else if (wr_en && addr_reg == AW'(gi)) begin
          regs_reg[gi] <= rx_byte;
        end
      end
      assign regs_flat[8*gi +: 8] = regs_reg[gi];
    end
  endgenerate

  assign tx_byte   = tx_byte_reg;
  assign tx_load   = tx_load_reg;
  assign wr_strobe = wr_strobe_reg;
  assign wr_addr   = wr_addr_reg;
  assign err_cnt   = err_cnt_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder with NUM_REGS=16; expected values are worked out
// by hand for each vector, and register contents are tracked in a small local model.
module tb_spi_cmd_decoder;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start, frame_end, rx_valid;
  logic [7:0]   rx_byte;
  logic [7:0]   tx_byte;
  logic         tx_load;
  logic [127:0] regs_flat;
  logic         wr_strobe;
  logic [3:0]   wr_addr;
  logic [7:0]   err_cnt;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  logic [3:0] wr_q[$];
  logic [7:0] model_regs [16];

  spi_cmd_decoder #(.NUM_REGS(16), .SYNC_BYTE(8'hA5), .ERR_BYTE(8'hEE)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .frame_end(frame_end),
    .rx_valid(rx_valid), .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load),
    .regs_flat(regs_flat), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
    .err_cnt(err_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_strobe) begin
      wr_cnt = wr_cnt + 1;
      wr_q.push_back(wr_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++)
      check($sformatf("%s reg%0d", tag, i), 32'(regs_flat[8*i +: 8]), 32'(model_regs[i]));
  endtask

  task automatic do_start();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  task automatic do_end();
    @(negedge clk); frame_end = 1'b1;
    @(negedge clk); frame_end = 1'b0;
  endtask

  task automatic do_byte(input logic [7:0] b, input logic with_end);
    @(negedge clk); rx_valid = 1'b1; rx_byte = b; frame_end = with_end;
    @(negedge clk); rx_valid = 1'b0; frame_end = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    idle(3);
    rst = 1'b0;
    idle(1);
    check("reset tx_byte", 32'(tx_byte), 32'h00);
    check("reset tx_load", 32'(tx_load), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    check("reset err_cnt", 32'(err_cnt), 32'h00);
    check("reset wr_strobe", 32'(wr_strobe), 32'h0);
    check("reset wr_addr", 32'(wr_addr), 32'h0);
    check_regs("reset");

    // Write burst at address 2
    wr_cnt = 0; wr_q.delete();
    do_start();
    check("wr sync tx", 32'(tx_byte), 32'hA5);
    check("wr sync load", 32'(tx_load), 32'h1);
    check("wr busy", 32'(busy), 32'h1);
    do_byte(8'h82, 1'b0); check("wr cmd echo", 32'(tx_byte), 32'h82);
    do_byte(8'h11, 1'b0); check("wr d0 echo", 32'(tx_byte), 32'h11);
    do_byte(8'h22, 1'b0); check("wr d1 echo", 32'(tx_byte), 32'h22);
    do_end();
    check("wr end tx", 32'(tx_byte), 32'h00);
    check("wr end busy", 32'(busy), 32'h0);
    idle(2);
    model_regs[2] = 8'h11; model_regs[3] = 8'h22;
    check("wr strobe count", 32'(wr_cnt), 32'd2);
    if (wr_q.size() == 2) begin
      check("wr strobe addr0", 32'(wr_q[0]), 32'd2);
      check("wr strobe addr1", 32'(wr_q[1]), 32'd3);
    end
    check_regs("wr");

    // Preload 15, 0, 1 with a wrapping write burst
    do_start();
    do_byte(8'h8F, 1'b0);
    do_byte(8'h5A, 1'b0);
    do_byte(8'hC3, 1'b0);
    do_byte(8'h7E, 1'b0);
    do_end();
    idle(1);
    model_regs[15] = 8'h5A; model_regs[0] = 8'hC3; model_regs[1] = 8'h7E;
    check_regs("wrap wr");

    // Read burst wrapping 15 -> 0 -> 1
    wr_cnt = 0;
    do_start();
    check("rd sync tx", 32'(tx_byte), 32'hA5);
    do_byte(8'h0F, 1'b0); check("rd reg15", 32'(tx_byte), 32'h5A);
    do_byte(8'h00, 1'b0); check("rd reg0", 32'(tx_byte), 32'hC3);
    do_byte(8'h00, 1'b0); check("rd reg1", 32'(tx_byte), 32'h7E);
    check("rd load", 32'(tx_load), 32'h1);
    do_end();
    idle(1);
    check("rd no strobe", 32'(wr_cnt), 32'd0);
    check_regs("rd");

    // Bad address 0x10
    wr_cnt = 0;
    do_start();
    do_byte(8'h90, 1'b0);
    check("bad tx", 32'(tx_byte), 32'hEE);
    check("bad err_cnt", 32'(err_cnt), 32'd1);
    do_byte(8'h77, 1'b0);
    check("bad ignore tx", 32'(tx_byte), 32'hEE);
    check("bad ignore load", 32'(tx_load), 32'h0);
    check("bad busy", 32'(busy), 32'h1);
    do_end();
    check("bad end busy", 32'(busy), 32'h0);
    check("bad end tx", 32'(tx_byte), 32'h00);
    idle(1);
    check("bad no strobe", 32'(wr_cnt), 32'd0);
    check("bad err hold", 32'(err_cnt), 32'd1);
    check_regs("bad");

    // Abort a write before any data; a following read proves the decoder is in CMD
    do_start();
    do_byte(8'h84, 1'b0);
    check("abort echo", 32'(tx_byte), 32'h84);
    do_start();
    check("abort sync tx", 32'(tx_byte), 32'hA5);
    check("abort busy", 32'(busy), 32'h1);
    check("abort reg4", 32'(regs_flat[39:32]), 32'h00);
    do_byte(8'h01, 1'b0);
    check("abort then read reg1", 32'(tx_byte), 32'h7E);
    do_end();

    // Last byte coincides with frame_end
    wr_cnt = 0; wr_q.delete();
    do_start();
    do_byte(8'h85, 1'b0);
    do_byte(8'h3C, 1'b1);
    check("simul strobe", 32'(wr_strobe), 32'h1);
    check("simul wr_addr", 32'(wr_addr), 32'd5);
    check("simul busy", 32'(busy), 32'h0);
    check("simul reg5", 32'(regs_flat[47:40]), 32'h3C);
    idle(1);
    check("simul strobe once", 32'(wr_cnt), 32'd1);
    check("simul strobe clear", 32'(wr_strobe), 32'h0);
    model_regs[5] = 8'h3C;

    // Reset in the middle of a write burst
    do_start();
    do_byte(8'h86, 1'b0);
    do_byte(8'h99, 1'b0);
    check("pre-rst reg6", 32'(regs_flat[55:48]), 32'h99);
    check("pre-rst busy", 32'(busy), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 8'h00;
    check("rst busy", 32'(busy), 32'h0);
    check("rst tx", 32'(tx_byte), 32'h00);
    check("rst err_cnt", 32'(err_cnt), 32'd0);
    check("rst wr_addr", 32'(wr_addr), 32'd0);
    check_regs("rst");

    // Error counter saturation
    for (int f = 0; f < 256; f++) begin
      do_start();
      do_byte(8'hFF, 1'b0);
      do_end();
      if (f == 253) check("sat 254 frames", 32'(err_cnt), 32'hFE);
      if (f == 254) check("sat 255 frames", 32'(err_cnt), 32'hFF);
    end
    check("sat 256 frames", 32'(err_cnt), 32'hFF);
    check_regs("sat");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
